// File: rtl/rf_arb_pkg.sv
// ---------------------------------------------------------------------------
// rf_arb_pkg
// Shared types and constants for the register-file write arbiter.
//   DATA_W / ADDR_W : write data / register address widths (16 x 16 RF)
//   FIFO_DEPTH_DEF  : default entries per requester FIFO
//   REQ_ALU/REQ_LD  : requester ids as seen on grant_id
//   wr_req_t        : one queued write {addr, data}
//   arb_pick()      : round-robin winner selection between two requesters
// ---------------------------------------------------------------------------
package rf_arb_pkg;

    localparam int DATA_W         = 16;
    localparam int ADDR_W         = 4;
    localparam int FIFO_DEPTH_DEF = 2;
    localparam int REQ_W          = ADDR_W + DATA_W;

    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_LD  = 1'b1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    // Winner of one arbitration round. On a conflict the requester that did
    // not win last time goes; otherwise whichever side has work. When
    // neither has work the result is don't-care (caller gates with valid).
    function automatic logic arb_pick(input logic rr_last,
                                      input logic vld0,
                                      input logic vld1);
        logic win;
        if (vld0 && vld1) begin
            win = ~rr_last;
        end else if (vld1) begin
            win = REQ_LD;
        end else begin
            win = REQ_ALU;
        end
        return win;
    endfunction

endpackage

// File: rtl/rf_wr_fifo.sv
// ---------------------------------------------------------------------------
// rf_wr_fifo
// Synchronous FIFO holding pending register-file writes (wr_req_t, flattened)
// for one requester.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (empties the FIFO)
//   push_i      : write din_i this cycle (ignored when full)
//   din_i       : entry to enqueue
//   pop_i       : drop the head this cycle (ignored when empty)
//   head_o      : oldest entry, valid while !empty_o
//   full_o      : DEPTH entries held
//   empty_o     : no entries held
// DEPTH must be a power of two and >= 2 so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module rf_wr_fifo
    import rf_arb_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [REQ_W-1:0] din_i,
    input  logic             pop_i,
    output logic [REQ_W-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [REQ_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic do_push;
    logic do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only visible once count covers it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter
// Shares the single write port of the 16x16 register file between the ALU
// writeback (requester 0) and the load/DMA writeback (requester 1). Each
// requester feeds its own rf_wr_fifo; a round-robin arbiter picks one head
// per cycle and registers it onto the RF write strobe.
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   req{0,1}_valid/_ready    : per-requester handshake, ready = !fifo_full
//   req{0,1}_addr/_data      : destination register and write data
//   rf_en, rf_wa, rf_wd      : registered write strobe into the RF
//   grant_id                 : requester owning the write on rf_* now
//   idle                     : both FIFOs empty and no write in flight
// Optional build macro:
//   RF_ARB_ZERO_REG_EN       : writes to register 0 are consumed but never
//                              strobed, so register 0 reads as constant zero.
//
// rr_last | meaning
// --------+-----------------------------------------------
//   0     | requester 0 won the last conflict; 1 wins next
//   1     | requester 1 won the last conflict; 0 wins next
// ---------------------------------------------------------------------------
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              rf_en,
    output logic [ADDR_W-1:0] rf_wa,
    output logic [DATA_W-1:0] rf_wd,
    output logic              grant_id,
    output logic              idle
);

    wr_req_t in0, in1;
    wr_req_t head0, head1;
    wr_req_t cand0, cand1;
    wr_req_t win_req;

    logic full0, full1;
    logic empty0, empty1;
    logic cand0_vld, cand1_vld;
    logic grant_vld;
    logic grant_sel;
    logic pop0, pop1;
    logic fifo_pop0, fifo_pop1;
    logic fifo_push0, fifo_push1;
    logic wr_en_c;

    logic              rr_last_q, rr_last_d;
    logic              rf_en_q;
    logic [ADDR_W-1:0] rf_wa_q;
    logic [DATA_W-1:0] rf_wd_q;
    logic              grant_id_q;

    assign in0 = '{addr: req0_addr, data: req0_data};
    assign in1 = '{addr: req1_addr, data: req1_data};

    assign req0_ready = !full0;
    assign req1_ready = !full1;

    // An entry accepted into an empty FIFO is offered to the arbiter in the
    // same cycle, so an accept at edge N puts the write on rf_* right after
    // edge N. Ready is always high when empty (DEPTH >= 2), so valid alone
    // means "accepted" here.
    assign cand0_vld = !empty0 || req0_valid;
    assign cand1_vld = !empty1 || req1_valid;
    assign cand0     = empty0 ? in0 : head0;
    assign cand1     = empty1 ? in1 : head1;

    assign grant_vld = cand0_vld || cand1_vld;
    assign grant_sel = arb_pick(rr_last_q, cand0_vld, cand1_vld);
    assign win_req   = (grant_sel == REQ_LD) ? cand1 : cand0;

    assign pop0 = grant_vld && (grant_sel == REQ_ALU);
    assign pop1 = grant_vld && (grant_sel == REQ_LD);

    // A bypassed entry is consumed directly and never lands in the FIFO.
    assign fifo_pop0  = pop0 && !empty0;
    assign fifo_pop1  = pop1 && !empty1;
    assign fifo_push0 = req0_valid && req0_ready && !(empty0 && pop0);
    assign fifo_push1 = req1_valid && req1_ready && !(empty1 && pop1);

`ifdef RF_ARB_ZERO_REG_EN
    assign wr_en_c = grant_vld && (win_req.addr != '0);
`else
    assign wr_en_c = grant_vld;
`endif

    always_comb begin
        rr_last_d = rr_last_q;
        if (cand0_vld && cand1_vld) begin
            rr_last_d = grant_sel;
        end
    end

    rf_wr_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push0),
        .din_i   (in0),
        .pop_i   (fifo_pop0),
        .head_o  (head0),
        .full_o  (full0),
        .empty_o (empty0)
    );

    rf_wr_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push1),
        .din_i   (in1),
        .pop_i   (fifo_pop1),
        .head_o  (head1),
        .full_o  (full1),
        .empty_o (empty1)
    );

    // rf_wa/rf_wd/grant_id only move on a grant, so they hold the last
    // write while the port is quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_q  <= REQ_LD;
            rf_en_q    <= 1'b0;
            rf_wa_q    <= '0;
            rf_wd_q    <= '0;
            grant_id_q <= REQ_ALU;
        end else begin
            rr_last_q <= rr_last_d;
            rf_en_q   <= wr_en_c;
            if (grant_vld) begin
                rf_wa_q    <= win_req.addr;
                rf_wd_q    <= win_req.data;
                grant_id_q <= grant_sel;
            end
        end
    end

    assign rf_en    = rf_en_q;
    assign rf_wa    = rf_wa_q;
    assign rf_wd    = rf_wd_q;
    assign grant_id = grant_id_q;
    assign idle     = empty0 && empty1 && !rf_en_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;

    localparam int DEPTH = 2;
`ifdef RF_ARB_ZERO_REG_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_addr, req1_addr;
    logic [15:0] req0_data, req1_data;
    logic        rf_en;
    logic [3:0]  rf_wa;
    logic [15:0] rf_wd;
    logic        grant_id;
    logic        idle;

    always #5 clk = ~clk;

    rf_write_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .rf_en      (rf_en),
        .rf_wa      (rf_wa),
        .rf_wd      (rf_wd),
        .grant_id   (grant_id),
        .idle       (idle)
    );

    // Register file driven by the arbiter's write port.
    logic [15:0] rf_mem [16] = '{default: 16'h0};
    always @(posedge clk) begin
        if (rf_en) rf_mem[rf_wa] <= rf_wd;
    end

    // ---------------- reference model ----------------
    typedef struct { logic [3:0] a; logic [15:0] d; } ent_t;
    typedef struct { logic id; logic [3:0] a; logic [15:0] d; } exp_t;

    ent_t        mq0[$];
    ent_t        mq1[$];
    exp_t        exp_q[$];
    bit          m_rr = 1'b1;
    bit          m_en = 1'b0;
    logic [15:0] model_reg [16] = '{default: 16'h0};

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    // Each edge: accept what the requesters offer (queue has room), then the
    // next write goes to the side with work; on a conflict, the side that
    // did not win the previous conflict.
    always @(posedge clk) begin
        bit   a0, a1, n0, n1;
        int   w;
        ent_t e;
        if (rst_n) begin
            a0 = req0_valid && (mq0.size() < DEPTH);
            a1 = req1_valid && (mq1.size() < DEPTH);
            if (a0) mq0.push_back('{req0_addr, req0_data});
            if (a1) mq1.push_back('{req1_addr, req1_data});
            n0 = (mq0.size() > 0);
            n1 = (mq1.size() > 0);
            w  = -1;
            if (n0 && n1) begin
                w    = m_rr ? 0 : 1;
                m_rr = (w == 1);
            end else if (n0) begin
                w = 0;
            end else if (n1) begin
                w = 1;
            end
            m_en = 1'b0;
            if (w == 0) e = mq0.pop_front();
            if (w == 1) e = mq1.pop_front();
            if (w >= 0 && !(ZERO_EN && e.a == 4'd0)) begin
                m_en = 1'b1;
                exp_q.push_back('{(w == 1), e.a, e.d});
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t x;
        if (rst_n) begin
            chk("ready0", req0_ready, (mq0.size() < DEPTH));
            chk("ready1", req1_ready, (mq1.size() < DEPTH));
            chk("idle", idle, (mq0.size() == 0 && mq1.size() == 0 && !m_en));
            chk("rf_en", rf_en, m_en);
            if (m_en && exp_q.size() > 0) begin
                x = exp_q.pop_front();
                model_reg[x.a] = x.d;
                if (rf_en) begin
                    chk("rf_wa", rf_wa, x.a);
                    chk("rf_wd", rf_wd, x.d);
                    chk("grant_id", grant_id, x.id);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive_idle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        drive_idle();
        mq0.delete();
        mq1.delete();
        exp_q.delete();
        m_rr = 1'b1;
        m_en = 1'b0;
        #1;
        chk("rst_async_en", rf_en, 1'b0);
        chk("rst_async_idle", idle, 1'b1);
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        chk("rst_en", rf_en, 1'b0);
        chk("rst_idle", idle, 1'b1);
        chk("rst_ready0", req0_ready, 1'b1);
        chk("rst_ready1", req1_ready, 1'b1);
        chk("rst_gid", grant_id, 1'b0);
        chk("rst_wa", rf_wa, 4'd0);
        chk("rst_wd", rf_wd, 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k, guard;
        bit rdy, saw_low;
        logic [15:0] tmp;

        rst_n = 1'b0;
        drive_idle();
        req0_addr = '0; req0_data = '0; req1_addr = '0; req1_data = '0;
        do_reset(2);

        // single write
        @(negedge clk);
        req0_valid = 1'b1; req0_addr = 4'd3; req0_data = 16'd23;
        @(negedge clk);
        drive_idle();
        repeat (3) @(negedge clk);
        chk("readback_r3", rf_mem[3], 16'd23);

        // conflict right after reset
        do_reset(2);
        @(negedge clk);
        req0_valid = 1'b1; req0_addr = 4'd5; req0_data = 16'd53;
        req1_valid = 1'b1; req1_addr = 4'd5; req1_data = 16'd99;
        @(negedge clk);
        drive_idle();
        repeat (4) @(negedge clk);
        chk("conflict_r5", rf_mem[5], 16'd99);

        // register 0 write
        @(negedge clk);
        req0_valid = 1'b1; req0_addr = 4'd0; req0_data = 16'hFFFF;
        @(negedge clk);
        drive_idle();
        repeat (3) @(negedge clk);
        chk("zero_reg_r0", rf_mem[0], ZERO_EN ? 16'h0000 : 16'hFFFF);

        // back-pressure: req0 streams, req1 offers 4 writes to one register
        k = 0; guard = 0; saw_low = 1'b0;
        @(negedge clk);
        while (k < 4 && guard < 50) begin
            req0_valid = 1'b1;
            req0_addr  = 4'($urandom_range(1, 15));
            req0_data  = 16'($urandom);
            req1_valid = 1'b1;
            req1_addr  = 4'd7;
            req1_data  = 16'h1000 + 16'(k);
            rdy = req1_ready;
            if (!rdy) saw_low = 1'b1;
            @(negedge clk);
            if (rdy) k++;
            guard++;
        end
        req1_valid = 1'b0;
        if (!req1_ready) saw_low = 1'b1;
        repeat (2) begin
            req0_addr = 4'($urandom_range(1, 15));
            req0_data = 16'($urandom);
            @(negedge clk);
        end
        drive_idle();
        repeat (4) @(negedge clk);
        chk("bp_accepts", k, 4);
        chk("bp_ready_drop", saw_low, 1'b1);
        chk("bp_last_r7", rf_mem[7], 16'h1003);

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            req0_valid = ($urandom_range(0, 9) < 6);
            req0_addr  = 4'($urandom);
            req0_data  = 16'($urandom);
            req1_valid = ($urandom_range(0, 9) < 6);
            req1_addr  = 4'($urandom);
            req1_data  = 16'($urandom);
            @(negedge clk);
        end

        // fill both FIFOs, then reset mid-stream
        for (int c = 0; c < 4; c++) begin
            req0_valid = 1'b1; req0_addr = 4'd9;  req0_data = 16'hA000 + 16'(c);
            req1_valid = 1'b1; req1_addr = 4'd10; req1_data = 16'hB000 + 16'(c);
            @(negedge clk);
        end
        tmp = 16'(mq0.size() + mq1.size());
        if (tmp < 16'd2) $display("note: fewer than two entries queued before reset");
        do_reset(2);
        repeat (6) @(negedge clk);
        chk("post_rst_idle", idle, 1'b1);

        for (int r = 0; r < 16; r++) begin
            chk($sformatf("final_r%0d", r), rf_mem[r], model_reg[r]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
